uart_sender: RTL and testbench

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 49 ++++
 rtl/uart_sender.sv | 162 ++++++++++++++++
 tb/tb_uart_sender.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART sender: transmit state encoding, frame
// constants and the parity helper. Optional feature macro used by the
// sender: UART_SENDER_PARITY_EN (adds an even-parity bit after d[7]).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART sender. While enable is high the counter
// runs 0..BPS_CNT-1 and tick marks the last cycle of every bit period; while
// enable is low the counter is held at 0 so a new frame starts aligned.
module uart_baud_tick #(
  parameter int CLK_FREQ = 65_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic enable,
  output logic tick
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tick_s;

  // Next count: hold at zero when idle, wrap after the last cycle of a bit.
  always_comb begin
    cnt_nxt_s = cnt_r;
    tick_s    = 1'b0;
    if (!enable) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = CNT_ZERO;
      tick_s    = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Counter register, cleared asynchronously by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/uart_sender.sv
// UART transmitter, 8 data bits LSB first, one stop bit, no flow control.
// A rising edge on uart_en while idle (or in the very last cycle of the stop
// bit, for gapless back-to-back frames) latches uart_din and starts a frame.
// Define UART_SENDER_PARITY_EN to insert an even-parity bit before the stop
// bit. uart_txd and uart_tx_busy come straight from flops.
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_txd,
  output logic       uart_tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_r;
  tx_state_e            state_nxt_s;
  logic [2:0]           bit_idx_r;
  logic [2:0]           bit_idx_nxt_s;
  logic [DATA_BITS-1:0] data_r;
  logic [DATA_BITS-1:0] data_nxt_s;
  logic                 en_d_r;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 txd_r;
  logic                 txd_nxt_s;
  logic                 start_s;
  logic                 tick_s;
  logic                 frame_end_s;
  logic                 accept_s;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_baud_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .enable  (busy_r),
    .tick    (tick_s)
  );

  // Request detection: only a fresh rising edge of uart_en counts, and it is
  // taken when idle or exactly on the cycle the current stop bit completes.
  always_comb begin
    start_s     = uart_en & ~en_d_r;
    frame_end_s = (state_r == STOP) & tick_s;
    accept_s    = start_s & (~busy_r | frame_end_s);
  end

  // Next-state logic for the frame sequencer; data is latched only on accept.
  always_comb begin
    state_nxt_s   = state_r;
    bit_idx_nxt_s = bit_idx_r;
    data_nxt_s    = data_r;
    busy_nxt_s    = busy_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s   = START;
          bit_idx_nxt_s = 3'd0;
          data_nxt_s    = uart_din;
          busy_nxt_s    = 1'b1;
        end else begin
          busy_nxt_s    = 1'b0;
        end
      end
      START: begin
        if (tick_s) begin
          state_nxt_s   = DATA;
          bit_idx_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_idx_r == LAST_BIT) begin
`ifdef UART_SENDER_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
            bit_idx_nxt_s = 3'd0;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        // Only reachable with the parity option; always moves on to STOP.
        if (tick_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (frame_end_s && accept_s) begin
          state_nxt_s   = START;
          bit_idx_nxt_s = 3'd0;
          data_nxt_s    = uart_din;
          busy_nxt_s    = 1'b1;
        end else if (frame_end_s) begin
          state_nxt_s   = IDLE;
          busy_nxt_s    = 1'b0;
        end else begin
          state_nxt_s   = STOP;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bit_idx_nxt_s = 3'd0;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so the
  // registered output lines up exactly with the state it belongs to.
  always_comb begin
    txd_nxt_s = IDLE_LEVEL;
    case (state_nxt_s)
      IDLE:    txd_nxt_s = IDLE_LEVEL;
      START:   txd_nxt_s = START_LEVEL;
      DATA:    txd_nxt_s = data_nxt_s[bit_idx_nxt_s];
      PARITY:  txd_nxt_s = even_parity(data_nxt_s);
      STOP:    txd_nxt_s = STOP_LEVEL;
      default: txd_nxt_s = IDLE_LEVEL;
    endcase
  end

  // State, data and output registers; reset aborts any frame in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      data_r    <= '0;
      en_d_r    <= 1'b0;
      busy_r    <= 1'b0;
      txd_r     <= IDLE_LEVEL;
    end else begin
      state_r   <= state_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      data_r    <= data_nxt_s;
      en_d_r    <= uart_en;
      busy_r    <= busy_nxt_s;
      txd_r     <= txd_nxt_s;
    end
  end

  assign uart_txd     = txd_r;
  assign uart_tx_busy = busy_r;

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender at CLK_FREQ=1000, UART_BPS=100 (10 cycles
// per bit). Expected line patterns are hand-written constants; define
// UART_SENDER_PARITY_EN to check the parity-enabled build.
module tb_uart_sender;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int BPS      = 10;
`ifdef UART_SENDER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAST = NB * BPS - 1;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       uart_en  = 1'b0;
  logic [7:0] uart_din = 8'h00;
  logic       uart_txd;
  logic       uart_tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_sender #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // line holds {stop, d7..d0, start}; bit 0 is the first bit on the wire.
  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] d);
    @(negedge sys_clk);
    uart_din = d;
    uart_en  = 1'b1;
  endtask

  // Samples every cycle of a frame starting with the first cycle after the
  // accepting edge; uart_din is scrambled each cycle and uart_en may be
  // raised/lowered at given cycle offsets.
  task automatic check_frame(input string name, input logic [9:0] line, input logic par,
                             input logic [7:0] din_drive, input int rise_at, input int fall_at);
    logic [10:0] exp;
    int bad_bit;
    int busy_lo;
    exp = (NB == 11) ? {line[9], par, line[8:0]} : {1'b0, line};
    busy_lo = 0;
    for (int b = 0; b < NB; b++) begin
      bad_bit = 0;
      for (int c = 0; c < BPS; c++) begin
        @(negedge sys_clk);
        if (uart_txd !== exp[b]) bad_bit++;
        if (uart_tx_busy !== 1'b1) busy_lo++;
        uart_din = din_drive;
        if (b * BPS + c == rise_at) uart_en = 1'b1;
        if (b * BPS + c == fall_at) uart_en = 1'b0;
      end
      n_cmp++;
      if (bad_bit != 0) begin
        n_bad++;
        $display("FAIL %s bit%0d: txd wrong in %0d of %0d cycles, required level %b",
                 name, b, bad_bit, BPS, exp[b]);
      end
    end
    n_cmp++;
    if (busy_lo != 0) begin
      n_bad++;
      $display("FAIL %s busy: low in %0d cycles, required high for all %0d",
               name, busy_lo, NB * BPS);
    end
  endtask

  task automatic check_idle(input string name, input int ncyc);
    int bad;
    bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: txd/busy not 1/0 in %0d of %0d cycles", name, bad, ncyc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h48, 10'b1010010000, 1'b0};
    vecs[1]  = '{8'h55, 10'b1010101010, 1'b0};
    vecs[2]  = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3]  = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[4]  = '{8'h6C, 10'b1011011000, 1'b0};
    vecs[5]  = '{8'h21, 10'b1001000010, 1'b0};
    vecs[6]  = '{8'h0A, 10'b1000010100, 1'b0};
    vecs[7]  = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[8]  = '{8'h6E, 10'b1011011100, 1'b1};
    vecs[9]  = '{8'h6F, 10'b1011011110, 1'b0};
    vecs[10] = '{8'h01, 10'b1000000010, 1'b1};

    // Reset state, with uart_en low.
    repeat (3) @(negedge sys_clk);
    chk("reset_txd", uart_txd, 1'b1);
    chk("reset_busy", uart_tx_busy, 1'b0);
    sys_rst = 1'b0;
    check_idle("post_reset_idle", 5);

    // Single frames from the table; uart_din is inverted during each frame.
    for (int i = 0; i < 11; i++) begin
      start_req(vecs[i].din);
      check_frame($sformatf("frame_%02h", vecs[i].din), vecs[i].line, vecs[i].par,
                  ~vecs[i].din, -1, 0);
      check_idle($sformatf("idle_after_%02h", vecs[i].din), 3);
    end

    // Second request at cycle 40 of a frame is discarded.
    start_req(8'h48);
    check_frame("busy_req_ignored", vecs[0].line, vecs[0].par, 8'h55, 39, 41);
    check_idle("no_queued_frame", 2 * NB * BPS);

    // uart_en held high across two frame lengths sends only one frame.
    start_req(8'hA5);
    check_frame("held_en_frame", vecs[7].line, vecs[7].par, 8'h00, -1, -1);
    check_idle("held_en_no_retrigger", 2 * NB * BPS);
    @(negedge sys_clk);
    uart_en = 1'b0;
    check_idle("held_en_released", 2);

    // Back-to-back: second rising edge lands in the busy-fall cycle.
    start_req(8'h21);
    check_frame("b2b_first_21", vecs[5].line, vecs[5].par, 8'h0A, LAST, 0);
    check_frame("b2b_second_0A", vecs[6].line, vecs[6].par, 8'hFF, -1, 0);
    check_idle("b2b_idle", 3);

    // Reset at cycle 35 of a frame aborts it immediately.
    start_req(8'h48);
    @(negedge sys_clk);
    uart_en = 1'b0;
    repeat (34) @(negedge sys_clk);
    @(posedge sys_clk);
    #2;
    sys_rst  = 1'b1;
    uart_din = 8'h6C;
    uart_en  = 1'b1;
    #1;
    chk("midframe_reset_txd", uart_txd, 1'b1);
    chk("midframe_reset_busy", uart_tx_busy, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("held_reset_txd", uart_txd, 1'b1);
    chk("held_reset_busy", uart_tx_busy, 1'b0);
    // uart_en is still high: release counts as a fresh rising edge.
    sys_rst = 1'b0;
    check_frame("after_reset_6C", vecs[4].line, vecs[4].par, 8'h00, -1, 0);
    check_idle("after_reset_idle", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
